alarm_buzzer: RTL and testbench

Sequential output stage placed directly downstream of the combinational alarm-condition block; it consumes the `sAlarm` level and turns it into a driver-facing buzzer pattern. A sustained alarm condition first runs a grace window during which the driver can dismiss it. The buzzer then beeps at a fixed cadence until the alarm is acknowledged, the condition clears, or a beep-count timeout expires. All outputs are Moore-decoded from registered state; there is no combinational input-to-output path.

---
 rtl/alarm_pkg.sv | 22 ++
 rtl/alarm_buzzer_if.sv | 27 ++
 rtl/alarm_tone_gen.sv | 63 ++++++
 rtl/alarm_buzzer.sv | 111 +++++++++++
 tb/tb_alarm_buzzer.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/alarm_pkg.sv
// Shared types and defaults for the alarm buzzer slice.
// State encoding, default timing constants and counter sizing.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRACE   = 2'd1,
    BEEP    = 2'd2,
    HOLDOFF = 2'd3
  } alarm_state_t;

  localparam int unsigned DEF_GRACE_CYCLES = 8;
  localparam int unsigned DEF_BEEP_HALF    = 4;
  localparam int unsigned DEF_MAX_BEEPS    = 16;

  function automatic int unsigned cnt_w(
    input int unsigned n
  );
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/alarm_buzzer_if.sv
// Driver-side bundle of the alarm buzzer.
// Alarm level and ack in, buzzer status out.
interface alarm_buzzer_if;

  logic sAlarm;
  logic sAck;
  logic sBuzz;
  logic sActive;
  logic sTimeout;

  modport master (
    output sAlarm,
    output sAck,
    input  sBuzz,
    input  sActive,
    input  sTimeout
  );

  modport slave (
    input  sAlarm,
    input  sAck,
    output sBuzz,
    output sActive,
    output sTimeout
  );

endinterface

// File: rtl/alarm_tone_gen.sv
// Beep cadence: phase counter within a period and a saturating
// count of completed periods; cleared while not beeping.
module alarm_tone_gen
  import alarm_pkg::*;
#(
  parameter int unsigned BEEP_HALF = DEF_BEEP_HALF,
  parameter int unsigned MAX_BEEPS = DEF_MAX_BEEPS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic buzz_o,
  output logic period_done_o,
  output logic last_beep_o
);

  localparam int unsigned PW = cnt_w(BEEP_HALF);
  localparam int unsigned BW = cnt_w(MAX_BEEPS);

  localparam logic [PW-1:0] PH_HALF = PW'(BEEP_HALF);
  localparam logic [PW-1:0] PH_LAST = PW'(2 * BEEP_HALF - 1);
  localparam logic [BW-1:0] BC_MAX  = BW'(MAX_BEEPS);
  localparam logic [BW-1:0] BC_LAST = BW'(MAX_BEEPS - 1);

  logic [PW-1:0] phase_q, phase_d;
  logic [BW-1:0] beeps_q, beeps_d;

  assign period_done_o = en_i & (phase_q == PH_LAST);
  assign buzz_o        = (phase_q < PH_HALF);
  assign last_beep_o   = (beeps_q == BC_LAST);

  // Advance phase; count a beep at each period end, saturating.
  always_comb begin
    phase_d = phase_q;
    beeps_d = beeps_q;
    if (clr_i) begin
      phase_d = '0;
      beeps_d = '0;
    end else if (en_i) begin
      if (period_done_o) begin
        phase_d = '0;
        if (beeps_q < BC_MAX) begin
          beeps_d = beeps_q + 1'b1;
        end
      end else begin
        phase_d = phase_q + 1'b1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
      beeps_q <= '0;
    end else begin
      phase_q <= phase_d;
      beeps_q <= beeps_d;
    end
  end

endmodule

// File: rtl/alarm_buzzer.sv
// Alarm buzzer FSM: grace window, beep cadence, ack/timeout holdoff.
// Build option ALARM_LATCH_EN keeps beeping after sAlarm drops.
module alarm_buzzer
  import alarm_pkg::*;
#(
  parameter int unsigned GRACE_CYCLES = DEF_GRACE_CYCLES,
  parameter int unsigned BEEP_HALF    = DEF_BEEP_HALF,
  parameter int unsigned MAX_BEEPS    = DEF_MAX_BEEPS
) (
  input logic         clk,
  input logic         rst_n,
  alarm_buzzer_if.slave bus
);

  localparam int unsigned GW = cnt_w(GRACE_CYCLES);
  localparam logic [GW-1:0] G_LAST = GW'(GRACE_CYCLES - 1);

  alarm_state_t  state_q, state_d;
  logic [GW-1:0] grace_q, grace_d;
  logic          tmo_q, tmo_d;

  logic tone_buzz;
  logic tone_done;
  logic tone_last;

  alarm_tone_gen #(
    .BEEP_HALF (BEEP_HALF),
    .MAX_BEEPS (MAX_BEEPS)
  ) u_tone (
    .clk           (clk),
    .rst_n         (rst_n),
    .clr_i         (state_q != BEEP),
    .en_i          (state_q == BEEP),
    .buzz_o        (tone_buzz),
    .period_done_o (tone_done),
    .last_beep_o   (tone_last)
  );

  // Next state: ack beats alarm drop beats counter expiry.
  always_comb begin
    state_d = state_q;
    grace_d = grace_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      IDLE: begin
        tmo_d = 1'b0;
        if (bus.sAlarm) begin
          state_d = GRACE;
          grace_d = '0;
        end
      end
      GRACE: begin
        if (bus.sAck) begin
          state_d = HOLDOFF;
          tmo_d   = 1'b0;
        end else if (!bus.sAlarm) begin
          state_d = IDLE;
        end else if (grace_q == G_LAST) begin
          state_d = BEEP;
        end else begin
          grace_d = grace_q + 1'b1;
        end
      end
      BEEP: begin
        if (bus.sAck) begin
          state_d = HOLDOFF;
          tmo_d   = 1'b0;
`ifdef ALARM_LATCH_EN
        end else if (tone_done && tone_last) begin
          state_d = HOLDOFF;
          tmo_d   = 1'b1;
        end
`else
        end else if (!bus.sAlarm) begin
          state_d = IDLE;
        end else if (tone_done && tone_last) begin
          state_d = HOLDOFF;
          tmo_d   = 1'b1;
        end
`endif
      end
      HOLDOFF: begin
        if (!bus.sAlarm) begin
          state_d = IDLE;
          tmo_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, grace counter and timeout flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grace_q <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grace_q <= grace_d;
      tmo_q   <= tmo_d;
    end
  end

  assign bus.sBuzz    = (state_q == BEEP) & tone_buzz;
  assign bus.sActive  = (state_q == GRACE) | (state_q == BEEP);
  assign bus.sTimeout = (state_q == HOLDOFF) & tmo_q;

endmodule

// File: tb/tb_alarm_buzzer.sv
// Bench for alarm_buzzer with GRACE=4, HALF=2, MAX=3.
// Vector tables per scenario, scoreboard of expected outputs.
module tb_alarm_buzzer;

  typedef struct packed {
    logic alarm;
    logic ack;
    logic buzz;
    logic act;
    logic tmo;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;

  vec_t       vecs[$];
  logic [2:0] sb[$];
  int         checks = 0;
  int         errors = 0;
  string      scen;

  always #5 clk = ~clk;

  alarm_buzzer_if bif();

  alarm_buzzer #(
    .GRACE_CYCLES (4),
    .BEEP_HALF    (2),
    .MAX_BEEPS    (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  task automatic add(
    input logic a, input logic k,
    input logic b, input logic v, input logic t
  );
    vec_t x;
    x.alarm = a;
    x.ack   = k;
    x.buzz  = b;
    x.act   = v;
    x.tmo   = t;
    vecs.push_back(x);
  endtask

  task automatic check(
    input string name,
    input logic [2:0] got,
    input logic [2:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: buzz/act/tmo got %b want %b",
               name, got, exp);
    end
  endtask

  function automatic logic [2:0] outs();
    return {bif.sBuzz, bif.sActive, bif.sTimeout};
  endfunction

  task automatic run();
    logic [2:0] e;
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      bif.sAlarm = vecs[i].alarm;
      bif.sAck   = vecs[i].ack;
      sb.push_back({vecs[i].buzz, vecs[i].act, vecs[i].tmo});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check($sformatf("%s[%0d]", scen, i), outs(), e);
    end
    vecs.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    bif.sAlarm = 1'b0;
    bif.sAck   = 1'b0;
    #1;
    check({scen, "_rst"}, outs(), 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic add_grace();
    for (int i = 0; i < 4; i++) add(1, 0, 0, 1, 0);
  endtask

  task automatic add_beeps(input logic a, input int n);
    for (int p = 0; p < n; p++) begin
      add(a, 0, 1, 1, 0);
      add(a, 0, 1, 1, 0);
      add(a, 0, 0, 1, 0);
      add(a, 0, 0, 1, 0);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    bif.sAlarm = 1'b0;
    bif.sAck   = 1'b0;
    #1;
    check("por", outs(), 3'b000);

    scen = "timeout";
    do_reset();
    add_grace();
    add_beeps(1, 3);
    add(1, 0, 0, 0, 1);
    add(1, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 0);
    run();

    scen = "pulse";
    do_reset();
    add(1, 0, 0, 1, 0);
    add(1, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0);
    run();

    scen = "ack_beep";
    do_reset();
    add_grace();
    add(1, 0, 1, 1, 0);
    add(1, 0, 1, 1, 0);
    add(1, 1, 0, 0, 0);
    add(1, 1, 0, 0, 0);
    add(1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 0);
    run();

    scen = "drop_beep";
    do_reset();
    add_grace();
    add(1, 0, 1, 1, 0);
    add(1, 0, 1, 1, 0);
`ifdef ALARM_LATCH_EN
    add(0, 0, 0, 1, 0);
    add(0, 0, 0, 1, 0);
    add_beeps(0, 2);
    add(0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0);
`else
    add(0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 0);
`endif
    run();

    scen = "ack_drop";
    do_reset();
    add(1, 0, 0, 1, 0);
    add(1, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 0);
    run();

    scen = "ack_hold";
    do_reset();
    add(1, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0);
    add(1, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 0);
    run();

    scen = "mid_rst";
    do_reset();
    add_grace();
    add(1, 0, 1, 1, 0);
    run();
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_async", outs(), 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_rst_rel", outs(), 3'b000);
    @(posedge clk);
    #1;
    check("mid_rst_idle", outs(), 3'b010);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
